// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath. Outputs are decoded from the state.
// Instructions take 3 to 5 cycles, plus 1 per memory wait cycle. The FSM holds in FETCH, MEM_RD and MEM_WR until mem_ready.
`timescale 1ns/1ps
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       ALUop,
  output logic             illegal,
  output logic             busy,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    I_EXEC   = 4'd10,
    I_WB     = 4'd11,
    ILLEGAL  = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  state_t state_q, state_d;
  logic   fetch_pend;
  logic   fetch_go;
  logic   retire;

  // The branch decision is made in the datapath by ANDing zero with pc_write_cond.
  logic unused_zero;
  assign unused_zero = zero;

  // Once a fetch has been issued it completes even if run drops before mem_ready.
  assign fetch_go = run | fetch_pend;
  assign state    = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      fetch_pend  <= 1'b0;
      instr_count <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pend <= (state_q == FETCH) && fetch_go && !mem_ready;
      if (retire) begin
        instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ALUop         = 2'b00;
    illegal       = 1'b0;
    busy          = 1'b1;

    case (state_q)
      FETCH: begin
        if (fetch_go) begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ALUop     = 2'b11;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = DECODE;
          end
        end else begin
          busy = 1'b0;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        ALUop     = 2'b11;
        case (opcode)
          OP_LW, OP_SW:     state_d = MEM_ADDR;
          OP_R:             state_d = R_EXEC;
          OP_BEQ:           state_d = BRANCH;
          OP_J:             state_d = JUMP;
          OP_ADDI, OP_SLTI: state_d = I_EXEC;
          default:          state_d = ILLEGAL;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ALUop     = 2'b11;
        state_d   = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        ALUop         = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ALUop     = (opcode == OP_SLTI) ? 2'b10 : 2'b11;
        state_d   = I_WB;
      end
      I_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      ILLEGAL: begin
        // PC already advanced in FETCH, so execution simply resumes at the next instruction.
        illegal = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (!rst_n) begin
      retire        = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'b00;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      ALUop         = 2'b00;
      illegal       = 1'b0;
      busy          = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: table of instructions plus hand sequences for waits, run control and reset.
`timescale 1ns/1ps
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n, run, zero, mem_ready;
  logic [5:0]  opcode;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal, busy;
  logic [1:0]  pc_source, alu_src_b, ALUop;
  logic [3:0]  state;
  logic [31:0] instr_count;

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ALUop(ALUop), .illegal(illegal), .busy(busy), .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pw; logic pwc; logic [1:0] ps; logic iord; logic mr; logic mw; logic irw;
    logic m2r; logic rd; logic rw; logic sa; logic [1:0] sb; logic [1:0] aop; logic ill; logic busy;
  } ctl_t;

  typedef struct packed { logic [3:0] st; ctl_t ctl; logic [31:0] cnt; } exp_t;

  typedef struct packed {
    logic [5:0] op; logic z; logic [2:0] n; logic [23:0] seq; logic ret;
  } vec_t;

  ctl_t act;
  assign act = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, ALUop, illegal, busy};

  exp_t        scb[$];
  vec_t        vt[10];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_cnt;

  // Expected control word per state, written straight from the state table.
  function automatic ctl_t ctl_of(input logic [3:0] st, input logic [5:0] op, input logic go, input logic mr);
    ctl_t c;
    c = '0;
    c.busy = 1'b1;
    case (st)
      4'd0:  if (go) begin c.mr = 1; c.sb = 2'b01; c.aop = 2'b11; c.irw = mr; c.pw = mr; end
             else c.busy = 1'b0;
      4'd1:  begin c.sb = 2'b11; c.aop = 2'b11; end
      4'd2:  begin c.sa = 1; c.sb = 2'b10; c.aop = 2'b11; end
      4'd3:  begin c.mr = 1; c.iord = 1; end
      4'd4:  begin c.rw = 1; c.m2r = 1; end
      4'd5:  begin c.mw = 1; c.iord = 1; end
      4'd6:  c.sa = 1;
      4'd7:  begin c.rw = 1; c.rd = 1; end
      4'd8:  begin c.sa = 1; c.aop = 2'b01; c.pwc = 1; c.ps = 2'b01; end
      4'd9:  begin c.pw = 1; c.ps = 2'b10; end
      4'd10: begin c.sa = 1; c.sb = 2'b10; c.aop = (op == 6'b001010) ? 2'b10 : 2'b11; end
      4'd11: c.rw = 1;
      4'd12: c.ill = 1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // One clock: drive at negedge, push expectation, pop and compare 1 ns later.
  task automatic cyc(input logic r, input logic mr, input logic go, input logic [3:0] st, input logic ret);
    exp_t e;
    @(negedge clk);
    run = r;
    mem_ready = mr;
    e.st = st;
    e.ctl = ctl_of(st, opcode, go, mr);
    e.cnt = exp_cnt;
    scb.push_back(e);
    #1;
    e = scb.pop_front();
    check("state", 64'(state), 64'(e.st));
    check("ctl", 64'(act), 64'(e.ctl));
    check("instr_count", 64'(instr_count), 64'(e.cnt));
    if (ret) exp_cnt++;
  endtask

  initial begin
    vt[0] = '{op: 6'b000000, z: 1'b0, n: 3'd4, seq: {8'h0, 4'd7, 4'd6, 4'd1, 4'd0}, ret: 1'b1};
    vt[1] = '{op: 6'b100011, z: 1'b0, n: 3'd5, seq: {4'h0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, ret: 1'b1};
    vt[2] = '{op: 6'b101011, z: 1'b0, n: 3'd4, seq: {8'h0, 4'd5, 4'd2, 4'd1, 4'd0}, ret: 1'b1};
    vt[3] = '{op: 6'b000100, z: 1'b1, n: 3'd3, seq: {12'h0, 4'd8, 4'd1, 4'd0}, ret: 1'b1};
    vt[4] = '{op: 6'b000100, z: 1'b0, n: 3'd3, seq: {12'h0, 4'd8, 4'd1, 4'd0}, ret: 1'b1};
    vt[5] = '{op: 6'b000010, z: 1'b0, n: 3'd3, seq: {12'h0, 4'd9, 4'd1, 4'd0}, ret: 1'b1};
    vt[6] = '{op: 6'b001000, z: 1'b0, n: 3'd4, seq: {8'h0, 4'd11, 4'd10, 4'd1, 4'd0}, ret: 1'b1};
    vt[7] = '{op: 6'b001010, z: 1'b0, n: 3'd4, seq: {8'h0, 4'd11, 4'd10, 4'd1, 4'd0}, ret: 1'b1};
    vt[8] = '{op: 6'b111111, z: 1'b0, n: 3'd3, seq: {12'h0, 4'd12, 4'd1, 4'd0}, ret: 1'b0};
    vt[9] = '{op: 6'b000001, z: 1'b0, n: 3'd3, seq: {12'h0, 4'd12, 4'd1, 4'd0}, ret: 1'b0};

    rst_n = 1'b0; run = 1'b1; mem_ready = 1'b0; opcode = 6'b0; zero = 1'b0; exp_cnt = 0;
    #3;
    check("reset state", 64'(state), 64'd0);
    check("reset count", 64'(instr_count), 64'd0);
    check("reset ctl forced 0", 64'(act), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven instructions, back to back with mem_ready=1.
    for (int v = 0; v < 10; v++) begin
      opcode = vt[v].op;
      zero   = vt[v].z;
      for (int i = 0; i < 32'(vt[v].n); i++) begin
        logic [3:0] s;
        s = vt[v].seq[4*i +: 4];
        cyc(1'b1, 1'b1, 1'b1, s, vt[v].ret && (i == 32'(vt[v].n) - 1));
      end
    end

    // lw with 3 wait cycles in MEM_RD: 8 cycles total.
    opcode = 6'b100011;
    cyc(1, 1, 1, 4'd0, 0);
    cyc(1, 1, 1, 4'd1, 0);
    cyc(1, 1, 1, 4'd2, 0);
    repeat (3) cyc(1, 0, 1, 4'd3, 0);
    cyc(1, 1, 1, 4'd3, 0);
    cyc(1, 1, 1, 4'd4, 1);

    // sw with 2 wait cycles in MEM_WR, retiring in the mem_ready cycle.
    opcode = 6'b101011;
    cyc(1, 1, 1, 4'd0, 0);
    cyc(1, 1, 1, 4'd1, 0);
    cyc(1, 1, 1, 4'd2, 0);
    repeat (2) cyc(1, 0, 1, 4'd5, 0);
    cyc(1, 1, 1, 4'd5, 1);

    // Halted, then a fetch that survives run dropping, then halted again.
    opcode = 6'b000010;
    repeat (3) cyc(0, 0, 0, 4'd0, 0);
    cyc(1, 0, 1, 4'd0, 0);
    repeat (2) cyc(0, 0, 1, 4'd0, 0);
    cyc(0, 1, 1, 4'd0, 0);
    cyc(0, 1, 1, 4'd1, 0);
    cyc(0, 1, 1, 4'd9, 1);
    cyc(0, 0, 0, 4'd0, 0);
    cyc(0, 1, 0, 4'd0, 0);

    // Asynchronous reset while waiting in MEM_RD.
    opcode = 6'b100011;
    cyc(1, 1, 1, 4'd0, 0);
    cyc(1, 1, 1, 4'd1, 0);
    cyc(1, 1, 1, 4'd2, 0);
    cyc(1, 0, 1, 4'd3, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async reset state", 64'(state), 64'd0);
    check("async reset count", 64'(instr_count), 64'd0);
    check("async reset mem_read", 64'(mem_read), 64'd0);
    check("async reset ctl", 64'(act), 64'd0);
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 1, 1, 4'd0, 0);
    cyc(1, 1, 1, 4'd1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback, and drives all datapath enables and muxes.
- Supplies the 2-bit ALUop consumed by the ALU control decoder, so one shared ALU serves PC increment, branch target, address and result computation.
- Also handles memory wait states, run/halt and the retired-instruction count.

Parameters:
- CNT_W, 32, width of retired-instruction counter instr_count.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  1 = allowed to start a new fetch; sampled only in FETCH.
- opcode  in  6  instruction register bits [31:26].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory handshake; 1 = current read/write completes this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero=1 (datapath ANDs).
- pc_source  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
- i_or_d  out  1  0 = memory address from PC, 1 = from ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load instruction register.
- mem_to_reg  out  1  1 = write-back data from MDR.
- reg_dst  out  1  1 = rd, 0 = rt.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- ALUop  out  2  00 R-type (funct decode), 01 sub (beq), 10 slt (slti), 11 add.
- illegal  out  1  one-cycle pulse on unsupported opcode.
- busy  out  1  0 only in FETCH while run=0.
- state  out  4  current state encoding, for debug.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, slti 001010. Any other opcode is illegal.
- State encodings:
  - FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5
  - R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, ILLEGAL 12
  - 13–15 unused; go to FETCH on the next edge.
- Reset (async, rst_n=0): state=FETCH, instr_count=0, illegal=0. Datapath enables are state-decoded and forced 0 while rst_n=0. All other outputs 0.
- Default for every output in every state is 0 unless listed below.
- FETCH:
  - If run=0: all outputs 0, busy=0, hold.
  - If run=1: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ALUop=11, pc_source=00.
  - ir_write=1 and pc_write=1 only in the cycle mem_ready=1; the FSM then goes to DECODE. Otherwise it holds with mem_read still 1.
  - run dropping while waiting does not abort a fetch once it has started: mem_read stays 1 until mem_ready.
- DECODE: alu_src_a=0, alu_src_b=11, ALUop=11. Next state by opcode:
  - lw/sw -> MEM_ADDR
  - R -> R_EXEC
  - beq -> BRANCH
  - j -> JUMP
  - addi/slti -> I_EXEC
  - otherwise -> ILLEGAL
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ALUop=11. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready=1, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next FETCH; retire.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready=1, then FETCH; retire in the mem_ready cycle.
- R_EXEC: alu_src_a=1, alu_src_b=00, ALUop=00. Next R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH; retire.
- BRANCH: alu_src_a=1, alu_src_b=00, ALUop=01, pc_write_cond=1, pc_source=01. Next FETCH; retire.
- JUMP: pc_write=1, pc_source=10. Next FETCH; retire.
- I_EXEC: alu_src_a=1, alu_src_b=10. ALUop=11 for addi, 10 for slti. Next I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH; retire. The opcode must stay stable (IR not written) from DECODE through I_WB.
- ILLEGAL: illegal=1 for exactly this cycle, no register or memory writes, next FETCH. The instruction is not counted. The PC has already advanced, so execution resumes at the next instruction.
- Retire: instr_count increments by 1 on the edge leaving the retiring state. It wraps from all-ones to 0 silently.
- Latencies with mem_ready always 1:
  - lw 5 cycles; sw, R, addi, slti 4 cycles; beq, j 3 cycles.
  - Each memory wait cycle adds 1.
- busy=1 in every state except FETCH with run=0.

Test Plan:
- Reset mid-MEM_RD (rst_n low asynchronously) -> state=0 and instr_count=0 immediately, without waiting for a clock edge; mem_read=0; after release with run=1, FETCH asserts mem_read.
- R-type add, mem_ready=1 -> states 0,1,6,7,0; ALUop=00 in R_EXEC; reg_write=1, reg_dst=1 in R_WB; instr_count 0->1.
- lw with mem_ready low for 3 cycles in MEM_RD -> state 3 held 4 cycles, mem_read=1 throughout; MEM_WB asserts reg_write=1 with mem_to_reg=1; total 8 cycles.
- beq with zero=1 -> BRANCH asserts ALUop=01, pc_write_cond=1, pc_source=01; slti -> I_EXEC ALUop=10; addi -> ALUop=11.
- opcode 111111 -> DECODE then ILLEGAL: illegal pulses 1 cycle, reg_write/mem_write stay 0, instr_count unchanged, back to FETCH.
- run=0 in FETCH -> busy=0, mem_read=0, state holds; set run=1 with mem_ready=0 then drop run -> mem_read stays 1 until mem_ready=1, ir_write and pc_write pulse once.
